s27_circuit: RTL and testbench

Gate-level sequential benchmark block, equivalent to the ISCAS'89 s27 circuit.
- Three D flip-flops, a fixed network of NOT/AND/OR/NAND/NOR gates, four primary inputs and one primary output.
- Used as a small reference or target circuit (for example, as a Trojan-insertion baseline) inside test harnesses.
- One clock; reset is synchronous and active-high.

---
 rtl/s27_circuit.sv | 52 +++++
 tb/tb_s27_circuit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/s27_circuit.sv
// ISCAS'89 s27 benchmark: three D flip-flops around a fixed NOT/AND/OR/NAND/NOR
// network, with a combinational (Mealy) primary output G17.
module s27_circuit (
    input  logic CK,
    input  logic reset,
    input  logic G0,
    input  logic G1,
    input  logic G2,
    input  logic G3,
    output logic G17
);

    logic r_g5;
    logic r_g6;
    logic r_g7;

    logic w_g8;
    logic w_g9;
    logic w_g10;
    logic w_g11;
    logic w_g12;
    logic w_g13;
    logic w_g14;
    logic w_g15;
    logic w_g16;

    assign w_g14 = ~G0;
    assign w_g12 = ~(G1 | r_g7);
    assign w_g8  = w_g14 & r_g6;
    assign w_g15 = w_g12 | w_g8;
    assign w_g16 = G3 | w_g8;
    assign w_g9  = ~(w_g16 & w_g15);
    assign w_g11 = ~(r_g5 | w_g9);
    assign w_g10 = ~(w_g14 | w_g11);
    assign w_g13 = ~(G2 | w_g12);

    // Output is taken straight from the network; reset never gates it.
    assign G17 = ~w_g11;

    always_ff @(posedge CK) begin
        if (reset) begin
            r_g5 <= 1'b0;
            r_g6 <= 1'b0;
            r_g7 <= 1'b0;
        end else begin
            r_g5 <= w_g10;
            r_g6 <= w_g11;
            r_g7 <= w_g13;
        end
    end

endmodule

// File: tb/tb_s27_circuit.sv
// Directed-vector bench for s27_circuit: checks G17 combinationally and the
// (G5,G6,G7) state after each rising edge against hand-derived values.
module tb_s27_circuit;

    logic CK;
    logic reset;
    logic G0;
    logic G1;
    logic G2;
    logic G3;
    logic G17;

    int unsigned n_checks;
    int unsigned n_pass;

    s27_circuit dut (
        .CK    (CK),
        .reset (reset),
        .G0    (G0),
        .G1    (G1),
        .G2    (G2),
        .G3    (G3),
        .G17   (G17)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs half a cycle away from the active edge.
    task automatic drive(input logic rst, input logic [3:0] g);
        @(negedge CK);
        reset = rst;
        {G3, G2, G1, G0} = g;
        #1;
    endtask

    task automatic out_is(input string tag, input logic exp);
        check(tag, {2'b00, G17}, {2'b00, exp});
    endtask

    task automatic edge_then_state(input string tag, input logic [2:0] exp);
        @(posedge CK);
        #1;
        check(tag, {dut.r_g5, dut.r_g6, dut.r_g7}, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        {G3, G2, G1, G0} = 4'b0000;

        // Reset, then idle with all inputs low: self-holding state 000.
        edge_then_state("reset_state", 3'b000);
        drive(1'b1, 4'b0000);
        edge_then_state("reset_hold", 3'b000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0000);
            out_is("idle_g17", 1'b1);
            edge_then_state("idle_state", 3'b000);
        end

        // G3 alone from 000: G11=1 drives G17 low and loads G6.
        drive(1'b0, 4'b1000);
        out_is("g3_from000_g17", 1'b0);
        edge_then_state("g3_from000_next", 3'b010);
        drive(1'b0, 4'b0000);
        out_is("s010_idle_g17", 1'b0);
        edge_then_state("s010_idle_next", 3'b010);
        drive(1'b0, 4'b0001);
        out_is("s010_g0_g17", 1'b1);
        edge_then_state("s010_g0_next", 3'b100);
        drive(1'b0, 4'b0000);
        out_is("s100_idle_g17", 1'b1);
        edge_then_state("s100_idle_next", 3'b000);

        // G1 alone from 000 sets G7, which then holds.
        drive(1'b0, 4'b0010);
        out_is("g1_from000_g17", 1'b1);
        edge_then_state("g1_from000_next", 3'b001);
        drive(1'b0, 4'b0000);
        out_is("s001_idle_g17", 1'b1);
        edge_then_state("s001_idle_next", 3'b001);

        // G3 with G7=1 keeps G17 high, unlike from 000.
        drive(1'b0, 4'b1000);
        out_is("g3_from001_g17", 1'b1);
        edge_then_state("g3_from001_next", 3'b001);

        // Reset mid-operation: nothing happens until the rising edge.
        drive(1'b1, 4'b0001);
        check("rst_before_edge", {dut.r_g5, dut.r_g6, dut.r_g7}, 3'b001);
        out_is("rst_before_edge_g17", 1'b1);
        edge_then_state("rst_mid_op", 3'b000);
        drive(1'b0, 4'b1000);
        out_is("after_rst_g3_g17", 1'b0);
        edge_then_state("after_rst_g3_next", 3'b010);

        // Reset raised between edges; G17 still follows the network.
        drive(1'b1, 4'b0000);
        check("rst_between_edges", {dut.r_g5, dut.r_g6, dut.r_g7}, 3'b010);
        out_is("rst_ungated_g17", 1'b0);
        edge_then_state("rst_between_next", 3'b000);
        out_is("rst_held_g17", 1'b1);
        drive(1'b1, 4'b0111);
        edge_then_state("rst_beats_inputs", 3'b000);

        // G0 alone from 000 loads G5; with G5=1, G11=0 so G17=1.
        drive(1'b0, 4'b0001);
        out_is("g0_from000_g17", 1'b1);
        edge_then_state("g0_from000_next", 3'b100);
        drive(1'b0, 4'b1110);
        out_is("s100_busy_g17", 1'b1);
        edge_then_state("s100_busy_next", 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
